// File: rtl/pu_riscv_if_aligner.sv
// Fetch parcel queue plus aligner: buffers BIU halfwords and emits one 16/32-bit instruction per cycle.
// Optional feature macro: PU_RISCV_RVC_EN (compressed instruction support).
module pu_riscv_if_aligner #(
    parameter int              XLEN           = 64,
    parameter int              PARCEL_SIZE    = 64,
    parameter int              DEPTH          = 8,
    parameter int              EXCEPTION_SIZE = 16,
    parameter logic [XLEN-1:0] PC_INIT        = 'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic [XLEN-1:0]            flush_pc,
    input  logic [PARCEL_SIZE-1:0]     parcel,
    input  logic [XLEN-1:0]            parcel_pc,
    input  logic [PARCEL_SIZE/16-1:0]  parcel_valid,
    input  logic                       parcel_misaligned,
    input  logic                       parcel_page_fault,
    output logic                       parcel_ready,
    input  logic                       id_stall,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic                       instr_valid,
    output logic                       instr_rvc,
    output logic [EXCEPTION_SIZE-1:0]  instr_exception,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int LANES  = PARCEL_SIZE / 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = $clog2(LANES);

    localparam logic [31:0] INSTR_NOP                      = 32'h0000_0013;
    localparam int          CAUSE_MISALIGNED_INSTRUCTION   = 0;
    localparam int          CAUSE_INSTRUCTION_ACCESS_FAULT = 1;
    localparam int          CAUSE_ILLEGAL_INSTRUCTION      = 2;
    localparam logic [EXCEPTION_SIZE-1:0] MIS_EXC =
        EXCEPTION_SIZE'(1) << CAUSE_MISALIGNED_INSTRUCTION;

    typedef enum logic [1:0] {ST_RUN, ST_MISPEND, ST_HALT} state_t;

    logic [15:0]         r_q_data [DEPTH];
    logic [DEPTH-1:0]    r_q_mis;
    logic [DEPTH-1:0]    r_q_flt;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [XLEN-1:0]     r_exp_pc;
    logic [XLEN-1:0]     r_head_pc;
    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]               r_instr;
    logic [XLEN-1:0]           r_instr_pc;
    logic                      r_instr_valid;
    logic                      r_instr_rvc;
    logic [EXCEPTION_SIZE-1:0] r_instr_exc;

    logic [LANE_W-1:0]         w_lo;
    logic                      w_found;
    logic [LANE_W:0]           w_pcnt;
    logic [LANE_W:0]           w_push_n;
    logic [XLEN-1:0]           w_lo_pc;
    logic                      w_push;
    logic [PTR_W-1:0]          w_rd_nxt;
    logic [15:0]               w_hd0;
    logic [15:0]               w_hd1;
    logic                      w_is32;
    logic                      w_avail;
    logic                      w_load;
    logic                      w_pop;
    logic [CNT_W-1:0]          w_pop_n;
    logic [31:0]               w_instr;
    logic                      w_rvc;
    logic [EXCEPTION_SIZE-1:0] w_exc;
    logic                      w_flush_mis;

    assign parcel_ready    = (r_count <= CNT_W'(DEPTH - LANES));
    assign occupancy       = r_count;
    assign instr           = r_instr;
    assign instr_pc        = r_instr_pc;
    assign instr_valid     = r_instr_valid;
    assign instr_rvc       = r_instr_rvc;
    assign instr_exception = r_instr_exc;

`ifdef PU_RISCV_RVC_EN
    assign w_flush_mis = flush_pc[0];
`else
    assign w_flush_mis = |flush_pc[1:0];
`endif

    // Lowest valid lane decides whether the parcel continues the expected stream.
    always_comb begin
        w_lo    = '0;
        w_found = 1'b0;
        w_pcnt  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (parcel_valid[i] && !w_found) begin
                w_lo    = LANE_W'(i);
                w_found = 1'b1;
            end
            w_pcnt = w_pcnt + (LANE_W + 1)'(parcel_valid[i]);
        end
    end

    assign w_lo_pc  = parcel_pc + XLEN'({w_lo, 1'b0});
    assign w_push   = parcel_ready & (|parcel_valid) & ~flush & (w_lo_pc == r_exp_pc);
    assign w_push_n = w_push ? w_pcnt : '0;

    assign w_rd_nxt = r_rd_ptr + PTR_W'(1);
    assign w_hd0    = r_q_data[r_rd_ptr];
    assign w_hd1    = r_q_data[w_rd_nxt];
    assign w_is32   = &w_hd0[1:0];
    assign w_avail  = w_is32 ? (r_count >= CNT_W'(2)) : (r_count != '0);
    assign w_load   = ~id_stall | ~r_instr_valid;
    assign w_pop    = w_load & w_avail & ~flush & (r_state == ST_RUN);
    assign w_pop_n  = w_pop ? (w_is32 ? CNT_W'(2) : CNT_W'(1)) : '0;

    always_comb begin
        w_instr = INSTR_NOP;
        w_rvc   = 1'b0;
        w_exc   = '0;
        w_exc[CAUSE_INSTRUCTION_ACCESS_FAULT] = r_q_flt[r_rd_ptr] | (w_is32 & r_q_flt[w_rd_nxt]);
        w_exc[CAUSE_MISALIGNED_INSTRUCTION]   = r_q_mis[r_rd_ptr] | (w_is32 & r_q_mis[w_rd_nxt]);
        if (w_is32) begin
            w_instr = {w_hd1, w_hd0};
        end else begin
`ifdef PU_RISCV_RVC_EN
            w_instr = {16'h0000, w_hd0};
            w_rvc   = 1'b1;
`else
            w_exc[CAUSE_ILLEGAL_INSTRUCTION] = 1'b1;
`endif
        end
    end

    // A misaligned restart emits one faulting NOP, then holds until the next flush.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = w_flush_mis ? ST_MISPEND : ST_RUN;
        end else if (r_state == ST_MISPEND && w_load) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rstn && w_push) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (parcel_valid[i]) begin
                    r_q_data[r_wr_ptr + PTR_W'(i) - PTR_W'(w_lo)] <= parcel[16*i +: 16];
                    r_q_mis[r_wr_ptr + PTR_W'(i) - PTR_W'(w_lo)]  <= parcel_misaligned;
                    r_q_flt[r_wr_ptr + PTR_W'(i) - PTR_W'(w_lo)]  <= parcel_page_fault;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_exp_pc      <= PC_INIT;
            r_head_pc     <= PC_INIT;
            r_instr       <= INSTR_NOP;
            r_instr_pc    <= PC_INIT;
            r_instr_valid <= 1'b0;
            r_instr_rvc   <= 1'b0;
            r_instr_exc   <= '0;
        end else if (flush) begin
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_exp_pc      <= flush_pc;
            r_head_pc     <= flush_pc;
            r_instr_valid <= 1'b0;
        end else begin
            r_count <= r_count + CNT_W'(w_push_n) - w_pop_n;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_pcnt);
                r_exp_pc <= r_exp_pc + XLEN'({w_pcnt, 1'b0});
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(w_pop_n);
                r_head_pc <= r_head_pc + (w_is32 ? XLEN'(4) : XLEN'(2));
            end
            if (w_load) begin
                if (r_state == ST_MISPEND) begin
                    r_instr_valid <= 1'b1;
                    r_instr       <= INSTR_NOP;
                    r_instr_pc    <= r_head_pc;
                    r_instr_rvc   <= 1'b0;
                    r_instr_exc   <= MIS_EXC;
                end else if (w_pop) begin
                    r_instr_valid <= 1'b1;
                    r_instr       <= w_instr;
                    r_instr_pc    <= r_head_pc;
                    r_instr_rvc   <= w_rvc;
                    r_instr_exc   <= w_exc;
                end else begin
                    r_instr_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pu_riscv_if_aligner.sv
// Bench for pu_riscv_if_aligner: directed scenarios plus random traffic against a halfword-queue model.
module tb_pu_riscv_if_aligner;
    localparam int          XLEN           = 64;
    localparam int          PARCEL_SIZE    = 64;
    localparam int          DEPTH          = 8;
    localparam int          EXCEPTION_SIZE = 16;
    localparam int          LANES          = PARCEL_SIZE / 16;
    localparam logic [63:0] PC_INIT        = 64'h8000_0000;
    localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;
    localparam int          C_MIS = 0;
    localparam int          C_FLT = 1;
    localparam int          C_ILL = 2;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      flush;
    logic [XLEN-1:0]           flush_pc;
    logic [PARCEL_SIZE-1:0]    parcel;
    logic [XLEN-1:0]           parcel_pc;
    logic [LANES-1:0]          parcel_valid;
    logic                      parcel_misaligned;
    logic                      parcel_page_fault;
    logic                      parcel_ready;
    logic                      id_stall;
    logic [31:0]               instr;
    logic [XLEN-1:0]           instr_pc;
    logic                      instr_valid;
    logic                      instr_rvc;
    logic [EXCEPTION_SIZE-1:0] instr_exception;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    pu_riscv_if_aligner #(
        .XLEN(XLEN), .PARCEL_SIZE(PARCEL_SIZE), .DEPTH(DEPTH),
        .EXCEPTION_SIZE(EXCEPTION_SIZE), .PC_INIT(PC_INIT)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .flush_pc(flush_pc),
        .parcel(parcel), .parcel_pc(parcel_pc), .parcel_valid(parcel_valid),
        .parcel_misaligned(parcel_misaligned), .parcel_page_fault(parcel_page_fault),
        .parcel_ready(parcel_ready), .id_stall(id_stall), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_rvc(instr_rvc),
        .instr_exception(instr_exception), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        flt;
        logic        mis;
    } hw_t;

    hw_t         q[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_pc;
    logic        m_rvc;
    logic [15:0] m_exc;
    logic [63:0] m_exp_pc;
    logic [63:0] m_head_pc;
    bit          m_mispend;
    bit          m_halt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit pc_misaligned(input logic [63:0] pc);
`ifdef PU_RISCV_RVC_EN
        return pc[0];
`else
        return pc[1:0] != 2'b00;
`endif
    endfunction

    // Next state from the inputs currently driven and the model state before the edge.
    function automatic void model_step();
        int          sz   = q.size();
        bit          rdy  = (DEPTH - sz) >= LANES;
        bit          load = !id_stall || !m_valid;
        int          lo   = -1;
        int          cnt  = 0;
        hw_t         h0;
        hw_t         h1;
        if (!rstn) begin
            q.delete();
            m_valid = 0; m_instr = INSTR_NOP; m_pc = PC_INIT; m_rvc = 0; m_exc = '0;
            m_exp_pc = PC_INIT; m_head_pc = PC_INIT; m_mispend = 0; m_halt = 0;
            return;
        end
        if (flush) begin
            q.delete();
            m_valid = 0;
            m_exp_pc = flush_pc; m_head_pc = flush_pc;
            m_mispend = pc_misaligned(flush_pc);
            m_halt = 0;
            return;
        end
        if (load) begin
            if (m_mispend) begin
                m_valid = 1; m_instr = INSTR_NOP; m_pc = m_head_pc; m_rvc = 0;
                m_exc = '0; m_exc[C_MIS] = 1'b1;
                m_mispend = 0; m_halt = 1;
            end else if (!m_halt && sz > 0 && (q[0].d[1:0] != 2'b11 || sz >= 2)) begin
                h0 = q.pop_front();
                m_valid = 1; m_pc = m_head_pc; m_exc = '0;
                m_exc[C_FLT] = h0.flt; m_exc[C_MIS] = h0.mis;
                if (h0.d[1:0] == 2'b11) begin
                    h1 = q.pop_front();
                    m_instr = {h1.d, h0.d}; m_rvc = 0;
                    m_exc[C_FLT] = h0.flt | h1.flt; m_exc[C_MIS] = h0.mis | h1.mis;
                    m_head_pc = m_head_pc + 4;
                end else begin
`ifdef PU_RISCV_RVC_EN
                    m_instr = {16'h0000, h0.d}; m_rvc = 1;
`else
                    m_instr = INSTR_NOP; m_rvc = 0; m_exc[C_ILL] = 1'b1;
`endif
                    m_head_pc = m_head_pc + 2;
                end
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (parcel_valid[i]) begin
                if (lo < 0) lo = i;
                cnt++;
            end
        end
        if (rdy && cnt > 0 && (parcel_pc + 64'(2 * lo)) == m_exp_pc) begin
            for (int i = 0; i < LANES; i++)
                if (parcel_valid[i])
                    q.push_back('{d: parcel[16*i +: 16], flt: parcel_page_fault, mis: parcel_misaligned});
            m_exp_pc = m_exp_pc + 64'(2 * cnt);
        end
    endfunction

    task automatic compare_all();
        chk("valid", 64'(instr_valid), 64'(m_valid));
        chk("instr", 64'(instr), 64'(m_instr));
        chk("pc", instr_pc, m_pc);
        chk("rvc", 64'(instr_rvc), 64'(m_rvc));
        chk("exc", 64'(instr_exception), 64'(m_exc));
        chk("occ", 64'(occupancy), 64'(q.size()));
        chk("ready", 64'(parcel_ready), 64'((DEPTH - q.size()) >= LANES));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_parcel(input logic [63:0] pc, input logic [LANES-1:0] m, input bit all32);
        logic [PARCEL_SIZE-1:0] pw;
        pw = {$urandom, $urandom};
        for (int i = 0; i < LANES; i++)
            if (all32 || $urandom_range(0, 1) == 1) pw[16*i +: 2] = 2'b11;
        parcel = pw; parcel_pc = pc; parcel_valid = m;
    endtask

    initial begin
        int          lo;
        int          hi;
        logic [3:0]  mk;
        logic [63:0] ppc;

        rstn = 0; flush = 0; flush_pc = '0; parcel = '0; parcel_pc = '0; parcel_valid = '0;
        parcel_misaligned = 0; parcel_page_fault = 0; id_stall = 0;
        tick(); tick();
        chk("rst_instr", 64'(instr), 64'(INSTR_NOP));
        chk("rst_pc", instr_pc, PC_INIT);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(parcel_ready), 64'd1);
        rstn = 1;

        // Two 32-bit instructions from one full parcel.
        parcel = {32'h0000_0013, 32'h0010_0093}; parcel_pc = 64'h8000_0000; parcel_valid = 4'hF;
        tick();
        parcel_valid = '0;
        tick();
        chk("p1_instr", 64'(instr), 64'h0010_0093);
        chk("p1_pc", instr_pc, 64'h8000_0000);
        chk("p1_valid", 64'(instr_valid), 64'd1);
        tick();
        chk("p2_instr", 64'(instr), 64'h0000_0013);
        chk("p2_pc", instr_pc, 64'h8000_0004);
        chk("p2_occ", 64'(occupancy), 64'd0);

        // Stale parcel beyond the expected PC is dropped.
        set_parcel(64'h8000_0010, 4'hF, 1'b1);
        tick();
        parcel_valid = '0;
        chk("drop_occ", 64'(occupancy), 64'd0);
        chk("drop_valid", 64'(instr_valid), 64'd0);

        // Fill under stall until the queue is full, then drain.
        flush = 1; flush_pc = 64'h8000_0004; tick(); flush = 0;
        id_stall = 1;
        set_parcel(64'h8000_0000, 4'hC, 1'b1); tick();
        parcel_valid = '0; tick();
        set_parcel(64'h8000_0008, 4'hF, 1'b1); tick();
        set_parcel(64'h8000_0010, 4'hF, 1'b1); tick();
        chk("full_occ", 64'(occupancy), 64'(DEPTH));
        chk("full_ready", 64'(parcel_ready), 64'd0);
        set_parcel(64'h8000_0018, 4'hF, 1'b1); tick();
        chk("full_hold_occ", 64'(occupancy), 64'(DEPTH));
        parcel_valid = '0; id_stall = 0;
        repeat (6) tick();
        chk("drain_occ", 64'(occupancy), 64'd0);

        // Fault on the upper half only, delivered by a second parcel.
        flush = 1; flush_pc = 64'h8000_0200; tick(); flush = 0;
        set_parcel(64'h8000_0200, 4'h1, 1'b1); tick();
        set_parcel(64'h8000_0200, 4'hE, 1'b0); parcel_page_fault = 1; tick();
        parcel_valid = '0; parcel_page_fault = 0; tick();
        chk("flt_bit", 64'(instr_exception[C_FLT]), 64'd1);
        chk("flt_pc", instr_pc, 64'h8000_0200);

        // Flush wins over a simultaneous push while an instruction is valid.
        set_parcel(64'h8000_0208, 4'hF, 1'b1); flush = 1; flush_pc = 64'h8000_0300;
        tick();
        flush = 0;
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_valid", 64'(instr_valid), 64'd0);
        set_parcel(64'h8000_0300, 4'hF, 1'b1); tick();
        parcel_valid = '0; tick();
        chk("fl_first_pc", instr_pc, 64'h8000_0300);
        chk("fl_first_valid", 64'(instr_valid), 64'd1);

`ifdef PU_RISCV_RVC_EN
        flush = 1; flush_pc = 64'h8000_0002; tick(); flush = 0;
        parcel = 64'h0001_0093_0010_0000; parcel_pc = 64'h8000_0000; parcel_valid = 4'hE;
        tick();
        parcel_valid = '0; tick();
        chk("rvc_instr", 64'(instr), 64'h0000_0010);
        chk("rvc_flag", 64'(instr_rvc), 64'd1);
        chk("rvc_pc", instr_pc, 64'h8000_0002);
        tick();
        chk("rvc_next", 64'(instr), 64'h0001_0093);
        chk("rvc_next_pc", instr_pc, 64'h8000_0004);
`endif

        for (int unsigned c = 0; c < 3000; c++) begin
            rstn     = ($urandom_range(0, 499) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            flush_pc = PC_INIT + 64'($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) flush_pc = flush_pc + 64'($urandom_range(1, 3));
            id_stall = ($urandom_range(0, 2) == 0);
            parcel_page_fault = ($urandom_range(0, 15) == 0);
            parcel_misaligned = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) begin
                lo = int'(m_exp_pc[2:1]);
                if ($urandom_range(0, 9) == 0) lo = $urandom_range(0, 3);
                hi = $urandom_range(lo, 3);
                mk = 4'((32'd1 << (hi + 1)) - 1) & ~4'((32'd1 << lo) - 1);
                ppc = {m_exp_pc[63:3], 3'b000};
                if ($urandom_range(0, 15) == 0) ppc = ppc + 64'd8;
                set_parcel(ppc, mk, 1'b0);
            end else begin
                parcel_valid = '0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
